// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//
// Parameterised serial pattern detector. It finds PATTERN in the stream of
// accepted bits, taking one bit per cycle in which enable=1. The first bit
// received is PATTERN[PAT_LEN-1]. The detector is a KMP automaton. Its state
// is the length of the longest pattern prefix that is also a suffix of the
// accepted history. Both the transition table and the border length are
// computed at elaboration from the parameters.
//
// Parameters
//   PAT_LEN  pattern length in bits (2..16)
//   PATTERN  target sequence, MSB first
//   OVERLAP  1 = overlapping (recursive) matches, 0 = non-overlapping
//   COUNT_W  match counter width (1..32)
//
// Ports
//   CLOCK        in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   X            in   serial data bit
//   enable       in   X is accepted only when 1; state is held otherwise
//   clear_count  in   synchronous clear of match_count / count_sat
//   Z            out  registered one-cycle match pulse (Moore)
//   match_count  out  saturating number of matches since reset/clear
//   count_sat    out  sticky flag: a match arrived while match_count was full
//
// Build option
//   SEQ_DETECT_COUNT_EN  when defined, the match counter is built. When it is
//                        undefined, match_count and count_sat are tied to 0
//                        and clear_count is ignored. Ports and Z timing are
//                        the same in both builds.
// -----------------------------------------------------------------------------
module seq_detect_param #(
  parameter int                 PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 COUNT_W = 8
) (
  input  logic               CLOCK,
  input  logic               resetn,
  input  logic               X,
  input  logic               enable,
  input  logic               clear_count,
  output logic               Z,
  output logic [COUNT_W-1:0] match_count,
  output logic               count_sat
);

  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
    $error("seq_detect_param: PAT_LEN must be in 2..16");
  end
  if (COUNT_W < 1 || COUNT_W > 32) begin : g_bad_count_w
    $error("seq_detect_param: COUNT_W must be in 1..32");
  end

  // The state must also be able to hold PAT_LEN, because the candidate
  // state reaches PAT_LEN on a full match.
  localparam int SW    = $clog2(PAT_LEN + 1);
  localparam int TBL_W = 2 * PAT_LEN * SW;

  typedef logic [SW-1:0] state_t;

  // ---------------------------------------------------------------------------
  // Elaboration-time table construction
  // ---------------------------------------------------------------------------

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic logic pat_bit(input int i);
    logic [31:0] t;
    t = 32'(PATTERN) >> (PAT_LEN - 1 - i);
    return t[0];
  endfunction

  // Full KMP transition. The history word is the s-bit pattern prefix
  // followed by b. The result is the longest pattern prefix that is a
  // suffix of that word, and it can be as large as PAT_LEN.
  function automatic int kmp_next(input int s, input logic b);
    int   best;
    int   j;
    logic ok;
    logic w_bit;
    best = 0;
    for (int k = 1; k <= s + 1; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        j     = s + 1 - k + i;
        w_bit = (j == s) ? b : pat_bit(j);
        if (pat_bit(i) != w_bit) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  // Longest proper border of PATTERN. This is the resume state after an
  // overlapping match.
  function automatic int longest_border();
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < PAT_LEN; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (pat_bit(i) != pat_bit(PAT_LEN - k + i)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  // The table is packed as SW-bit entries indexed by {state, bit}.
  function automatic logic [TBL_W-1:0] build_next();
    logic [TBL_W-1:0] tbl;
    tbl = '0;
    for (int s = 0; s < PAT_LEN; s++) begin
      for (int b = 0; b < 2; b++) begin
        tbl = tbl | (TBL_W'(kmp_next(s, b != 0)) << ((2 * s + b) * SW));
      end
    end
    return tbl;
  endfunction

  localparam logic [TBL_W-1:0] NEXT_TBL = build_next();
  localparam state_t           BORDER   = state_t'(longest_border());
  localparam state_t           FULL     = state_t'(PAT_LEN);

  // ---------------------------------------------------------------------------
  // Detector FSM
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;
  state_t cand;
  logic   z_q, z_d;
  logic   match;

  // State register
  // NOTE: the reset sits in the sensitivity list, so resetn clears the flops at
  // once, without waiting for a clock edge.
  always_ff @(posedge CLOCK or negedge resetn) begin
    if (!resetn) begin
      state_q <= '0;
      z_q     <= 1'b0;
    end else begin
      // NOTE: use non-blocking assignments for flops so that every register
      // samples the values from before the edge, whatever the process order.
      state_q <= state_d;
      z_q     <= z_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: give every output of a combinational block a default first. A path
    // that leaves one unassigned infers a latch.
    cand    = state_t'(NEXT_TBL >> (int'({state_q, X}) * SW));
    state_d = state_q;
    z_d     = 1'b0;
    match   = 1'b0;
    if (enable) begin
      if (cand == FULL) begin
        match   = 1'b1;
        z_d     = 1'b1;
        state_d = OVERLAP ? BORDER : '0;
      end else begin
        state_d = cand;
      end
    end
  end

  // Output logic: Z comes only from the register
  always_comb begin
    Z = z_q;
  end

  // ---------------------------------------------------------------------------
  // Optional saturating match counter
  // ---------------------------------------------------------------------------
`ifdef SEQ_DETECT_COUNT_EN
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic [COUNT_W-1:0] count_q, count_d;
  logic               sat_q, sat_d;

  // clear_count takes priority over a match on the same edge. Z still
  // pulses, because Z is produced by the FSM and not by the counter.
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clear_count) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (match) begin
      if (count_q == COUNT_MAX) sat_d = 1'b1;
      else                      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign match_count = count_q;
  assign count_sat   = sat_q;
`else
  logic unused_count_inputs;
  assign unused_count_inputs = clear_count ^ match;

  assign match_count = '0;
  assign count_sat   = 1'b0;
`endif

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_LEN, default 3: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 3'b011 (PAT_LEN bits wide): target sequence; PATTERN[PAT_LEN-1] is the first bit received.
REQ-003 Parameter OVERLAP, default 1: 1 = recursive detection, 0 = non-overlapping detection.
REQ-004 Parameter COUNT_W, default 8: match counter width, legal range 1..32.
REQ-005 CLOCK  input  1  single clock; all state changes on its rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 X  input  1  serial data bit.
REQ-008 enable  input  1  X is sampled only in cycles where enable=1.
REQ-009 clear_count  input  1  synchronous clear of match_count and count_sat.
REQ-010 Z  output  1  registered one-cycle match pulse.
REQ-011 match_count  output  COUNT_W  number of matches since the last reset or clear.
REQ-012 count_sat  output  1  sticky flag: match_count has saturated.

Function
REQ-013 The FSM state S is an integer 0..PAT_LEN-1: the length of the longest pattern prefix that equals a suffix of the accepted bit history.
REQ-014 On an accepted bit (enable=1), the candidate S' is the longest prefix of PATTERN that is a suffix of (the current S-bit prefix followed by X); this is a full KMP transition, never a blind reset to 0.
REQ-015 If S' < PAT_LEN, S loads S' and Z is 0 in the next cycle.
REQ-016 If S' = PAT_LEN, that bit is a match: Z=1 for exactly the next cycle.
REQ-017 On a match with OVERLAP=1, S loads the length of the longest proper border of PATTERN.
REQ-018 On a match with OVERLAP=0, S loads 0.
REQ-019 Latency is 1 cycle: Z is asserted in the cycle after the edge that accepted the final pattern bit.
REQ-020 Z is a Moore output, driven only from a register and never combinationally from X.
REQ-021 When enable=0, S is held, Z=0 in the next cycle, and X is ignored; idle gaps never break a partial match.
REQ-022 match_count increments by 1 on the same edge that sets Z.
REQ-023 match_count saturates at 2^COUNT_W-1; a match that would exceed this holds the count and sets count_sat.
REQ-024 count_sat, once set, stays set until reset or clear_count.
REQ-025 clear_count=1 loads match_count=0 and count_sat=0 on the next edge; it does not affect S or Z.
REQ-026 If clear_count and a match occur on the same edge, clear wins: match_count=0 and the match is not counted, but Z still pulses.
REQ-027 The transition and border tables are derived from the parameters at elaboration, with no runtime configuration.

Reset
REQ-028 resetn=0 immediately, without waiting for a clock edge, forces S=0, Z=0, match_count=0 and count_sat=0.
REQ-029 Reset asserted mid-pattern discards the partial match; detection restarts from S=0 on the first accepted bit after resetn returns high.
REQ-030 Deassertion of resetn is assumed synchronous to CLOCK upstream; the block adds no synchronizer.

Configuration
REQ-031 Macro SEQ_DETECT_COUNT_EN, when defined, compiles in match_count, count_sat and clear_count behaviour per REQ-022..REQ-026.
REQ-032 When SEQ_DETECT_COUNT_EN is undefined, the counter logic is omitted, match_count is tied to 0, count_sat is tied to 0, and clear_count is ignored.
REQ-033 The ports are identical in both builds, and Z timing is unchanged.

Verification
REQ-034 Defaults, enable=1, X=0,1,1,0,1,1 -> Z pulses exactly in the cycles after the 3rd and 6th bits; match_count=2.
REQ-035 PATTERN=4'b1011, PAT_LEN=4, X=1,0,1,1,0,1,1 -> OVERLAP=1 gives Z after bits 4 and 7 (count 2); OVERLAP=0 gives Z after bit 4 only (count 1).
REQ-036 Defaults, X=0 (en=1), X=1 (en=0), X=1 (en=1), X=1 (en=1) -> the en=0 bit is ignored, and Z pulses after the final bit only.
REQ-037 Defaults, accept 0,1, drop resetn low between edges -> Z, S and match_count are 0 before the next edge; then accept 1 -> no Z.
REQ-038 COUNT_W=4, 16 matches -> match_count=15 and count_sat=1; then clear_count coinciding with the 17th match -> Z=1, match_count=0, count_sat=0.
REQ-039 Build without SEQ_DETECT_COUNT_EN, run REQ-034 stimulus -> identical Z, with match_count=0 and count_sat=0 throughout.
